// File: rtl/corescore_receiver_uart.sv
// 8N1 UART receiver with a one-byte holding register, frame-error and overrun pulses.
// All decisions use the synchronised line; sample points are centred on each bit.
module corescore_receiver_uart #(
    parameter int clk_freq_hz = 0,
    parameter int baud_rate   = 57600
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_uart_rx,
    output logic [7:0] o_data,
    output logic       o_valid,
    input  logic       i_ready,
    output logic       o_frame_err,
    output logic       o_overrun
);

    // A divider below 2 would leave no room for a mid-bit sample, so clamp it.
    localparam int DIV_RAW = (baud_rate > 0) ? (clk_freq_hz / baud_rate) : 0;
    localparam int DIV     = (DIV_RAW < 2) ? 2 : DIV_RAW;
    localparam int HALF    = DIV / 2;
    localparam int CW      = $clog2(DIV) + 1;

    localparam logic [CW-1:0] C_ZERO    = {CW{1'b0}};
    localparam logic [CW-1:0] C_ONE     = CW'(1);
    localparam logic [CW-1:0] C_DIV_M1  = CW'(DIV - 1);
    localparam logic [CW-1:0] C_HALF_M1 = CW'(HALF - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_STOP      = 3'd3,
        S_WAIT_IDLE = 3'd4
    } state_t;

    logic          r_sync1;
    logic          r_rxs;
    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_idx;
    logic [7:0]    r_shift;
    logic          r_done;
    logic          r_frame_err;
    logic [7:0]    r_data;
    logic          r_valid;
    logic          r_overrun;

    state_t        w_state_nxt;
    logic [CW-1:0] w_cnt_nxt;
    logic [2:0]    w_idx_nxt;
    logic [7:0]    w_shift_nxt;
    logic          w_done_nxt;
    logic          w_ferr_nxt;
    logic          w_expired;

    // Two-flop synchroniser on the asynchronous serial line, idling high.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync1 <= 1'b1;
            r_rxs   <= 1'b1;
        end else begin
            r_sync1 <= i_uart_rx;
            r_rxs   <= r_sync1;
        end
    end

    // Receiver FSM state, bit timer, bit index and shift register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= C_ZERO;
            r_idx       <= 3'd0;
            r_shift     <= 8'h00;
            r_done      <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_idx       <= w_idx_nxt;
            r_shift     <= w_shift_nxt;
            r_done      <= w_done_nxt;
            r_frame_err <= w_ferr_nxt;
        end
    end

    assign w_expired = (r_cnt == C_ZERO);

    // Next-state logic: each timed state samples the line when its timer reaches zero.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_shift_nxt = r_shift;
        w_done_nxt  = 1'b0;
        w_ferr_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!r_rxs) begin
                    w_state_nxt = S_START;
                    w_cnt_nxt   = C_HALF_M1;
                end else begin
                    w_cnt_nxt   = C_ZERO;
                end
            end
            S_START: begin
                if (w_expired) begin
                    if (!r_rxs) begin
                        w_state_nxt = S_DATA;
                        w_cnt_nxt   = C_DIV_M1;
                        w_idx_nxt   = 3'd0;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - C_ONE;
                end
            end
            S_DATA: begin
                if (w_expired) begin
                    w_shift_nxt = {r_rxs, r_shift[7:1]};
                    w_cnt_nxt   = C_DIV_M1;
                    if (r_idx == 3'd7) begin
                        w_state_nxt = S_STOP;
                    end else begin
                        w_idx_nxt   = r_idx + 3'd1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - C_ONE;
                end
            end
            S_STOP: begin
                if (w_expired) begin
                    if (r_rxs) begin
                        w_done_nxt  = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_ferr_nxt  = 1'b1;
                        w_state_nxt = S_WAIT_IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - C_ONE;
                end
            end
            S_WAIT_IDLE: begin
                if (r_rxs) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_WAIT_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = C_ZERO;
            end
        endcase
    end

    // Holding register: a completed byte loads if the slot is free or being drained this cycle.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_data    <= 8'h00;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (r_done) begin
                if (!r_valid || i_ready) begin
                    r_data  <= r_shift;
                    r_valid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_valid && i_ready) begin
                r_valid <= 1'b0;
            end else begin
                r_valid <= r_valid;
            end
        end
    end

    assign o_data      = r_data;
    assign o_valid     = r_valid;
    assign o_frame_err = r_frame_err;
    assign o_overrun   = r_overrun;

endmodule
